gb_cpu_regfile: RTL and testbench
=================================

GB_CPU_REGFILE -- requirements
Module: gb_cpu_regfile

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset. The ports are named clk and reset, as the codebase does.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- reset, in, 1: async active-low reset.
- alu_req, in, regfile_r8_t: ALU destination byte register.
- alu_data, in, 8: ALU result.
- alu_flags, in, alu_flags_t {z,n,h,c}: ALU flags.
- alu_wren, in, 1: ALU write enable.
- alu_skip_flags, in, 1: suppress the flag update on an ALU write.
- idu_req, in, regfile_r16_t: IDU destination register pair.
- idu_data, in, 16: IDU result.
- idu_wren, in, 1: IDU write enable.
- data_bus_req, in, regfile_r8_t: data-bus destination byte register.
- data_bus_data, in, 8: byte read from the bus.
- data_bus_wren, in, 1: data-bus write enable.
- set_adj, in, 1: latch the signed-offset adjust info.
- overwrite_sp, in, 1: copy HL into SP.
- registers, out, regfile_t: full register state, driven directly from flops.
REQ-003 regfile_r8_t SHALL enumerate A, B, C, D, E, H, L, W, Z, IR, IE, SPH, SPL, PCH, PCL.
REQ-004 regfile_r16_t SHALL enumerate BC, DE, HL, WZ, SP, PC.
REQ-005 regfile_t SHALL contain:
- 8-bit fields a, b, c, d, e, h, l, w, z, ir, ie.
- flags (alu_flags_t).
- 16-bit fields sp and pc.
- 1-bit fields adj_sign and adj_carry.

Function
REQ-006 All state SHALL update only on the rising clk edge, except for reset.
REQ-007 With alu_wren=1, the register selected by alu_req SHALL load alu_data.
REQ-008 With alu_wren=1 and alu_skip_flags=0, flags SHALL load alu_flags. With alu_skip_flags=1, flags SHALL hold.
REQ-009 With alu_wren=0, flags SHALL hold regardless of alu_skip_flags.
REQ-010 With data_bus_wren=1, the register selected by data_bus_req SHALL load data_bus_data.
REQ-011 With idu_wren=1, the pair selected by idu_req SHALL load idu_data, high byte first in the pair name. For example, BC means b<=idu_data[15:8] and c<=idu_data[7:0]; SP and PC load whole.
REQ-012 SPH/SPL and PCH/PCL byte writes SHALL modify only the addressed half of sp/pc.
REQ-013 With overwrite_sp=1, sp SHALL load {h,l} as they stand before the edge.
REQ-014 With set_adj=1, adj_sign SHALL load z[7] (pre-edge) and adj_carry SHALL load alu_flags.c. Otherwise both SHALL hold.
REQ-015 Writes from different sources to disjoint bytes in the same cycle SHALL all take effect.
REQ-016 Same-byte conflicts SHALL resolve with priority overwrite_sp > alu > data_bus > idu. Losing writes SHALL be dropped for that byte only.
REQ-017 Unselected registers SHALL hold their value.
REQ-018 The module SHALL have no combinational path from inputs to registers; register updates SHALL be visible the cycle after the write edge.
REQ-019 An enable low SHALL make the corresponding req/data inputs don't-care.

Reset
REQ-020 reset=0 SHALL immediately (asynchronously) clear every field of registers to 0: all 8-bit registers, flags {0,0,0,0}, sp=0x0000, pc=0x0000, adj_sign=0, adj_carry=0.
REQ-021 While reset=0, all write enables SHALL be ignored.
REQ-022 Normal operation SHALL resume on the first rising edge after reset returns to 1.
REQ-023 Asserting reset mid-operation SHALL discard any pending write.

Verification
REQ-024 Reset check: assert reset=0 between edges -> all registers 0 without a clock edge. Release -> values hold until the first write.
REQ-025 ALU write: alu_req=A, alu_data=0x5A, alu_flags={1,0,1,1}, alu_wren=1, skip=0 -> a=0x5A, flags={1,0,1,1}. Repeat with skip=1 and flags={0,0,0,0} -> a updates, flags remain {1,0,1,1}.
REQ-026 IDU pair writes:
- idu_req=HL, idu_data=0xC0DE -> h=0xC0, l=0xDE.
- idu_req=PC, idu_data=0x0150 -> pc=0x0150.
- Data-bus write SPL=0x34 then SPH=0x12 -> sp=0x1234.
REQ-027 Simultaneous writes:
- ALU A=0x11, bus B=0x22, IDU DE=0x3344 in one cycle -> all three apply.
- ALU and bus both target C with 0xAA/0xBB -> c=0xAA.
REQ-028 overwrite_sp: with h=0xDF, l=0xF0, overwrite_sp=1 and idu_req=SP with idu_data=0x0000 in the same cycle -> sp=0xDFF0.
REQ-029 set_adj: with z=0x80 and alu_flags.c=1, pulse set_adj -> adj_sign=1, adj_carry=1. With set_adj=0 on the next cycle -> both hold.

Source files
------------

// File: rtl/gb_cpu_regfile.sv
// gb_cpu_regfile_pkg / gb_cpu_regfile
//
// Game Boy CPU register file. Three write sources (ALU byte, data-bus byte,
// IDU register pair) plus an SP<-HL copy and latching of the signed-offset
// adjust info. The whole register state is exposed on 'registers', driven
// straight from flops.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset, clears all state
//   alu_req        ALU destination byte register
//   alu_data       ALU result byte
//   alu_flags      ALU flags {z,n,h,c}
//   alu_wren       ALU write enable
//   alu_skip_flags keep flags unchanged on an ALU write
//   idu_req        IDU destination register pair
//   idu_data       IDU 16-bit result
//   idu_wren       IDU write enable
//   data_bus_req   data-bus destination byte register
//   data_bus_data  byte read from the bus
//   data_bus_wren  data-bus write enable
//   set_adj        latch adj_sign <= z[7], adj_carry <= alu_flags.c
//   overwrite_sp   copy HL into SP
//   registers      full register state

package gb_cpu_regfile_pkg;

    typedef enum logic [3:0] {
        A, B, C, D, E, H, L, W, Z, IR, IE, SPH, SPL, PCH, PCL
    } regfile_r8_t;

    typedef enum logic [2:0] {
        BC, DE, HL, WZ, SP, PC
    } regfile_r16_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [7:0]  d;
        logic [7:0]  e;
        logic [7:0]  h;
        logic [7:0]  l;
        logic [7:0]  w;
        logic [7:0]  z;
        logic [7:0]  ir;
        logic [7:0]  ie;
        alu_flags_t  flags;
        logic [15:0] sp;
        logic [15:0] pc;
        logic        adj_sign;
        logic        adj_carry;
    } regfile_t;

endpackage

module gb_cpu_regfile
    import gb_cpu_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  regfile_r8_t  alu_req,
    input  logic [7:0]   alu_data,
    input  alu_flags_t   alu_flags,
    input  logic         alu_wren,
    input  logic         alu_skip_flags,
    input  regfile_r16_t idu_req,
    input  logic [15:0]  idu_data,
    input  logic         idu_wren,
    input  regfile_r8_t  data_bus_req,
    input  logic [7:0]   data_bus_data,
    input  logic         data_bus_wren,
    input  logic         set_adj,
    input  logic         overwrite_sp,
    output regfile_t     registers
);

    regfile_t nxt;

    // Byte write into one register; SP/PC halves touch only their byte.
    function automatic regfile_t write_r8(input regfile_t r, input regfile_r8_t sel,
                                          input logic [7:0] d);
        regfile_t o;
        o = r;
        case (sel)
            A:       o.a        = d;
            B:       o.b        = d;
            C:       o.c        = d;
            D:       o.d        = d;
            E:       o.e        = d;
            H:       o.h        = d;
            L:       o.l        = d;
            W:       o.w        = d;
            Z:       o.z        = d;
            IR:      o.ir       = d;
            IE:      o.ie       = d;
            SPH:     o.sp[15:8] = d;
            SPL:     o.sp[7:0]  = d;
            PCH:     o.pc[15:8] = d;
            PCL:     o.pc[7:0]  = d;
            default: o          = r;
        endcase
        return o;
    endfunction

    // Pair write, high byte of the data goes to the first-named register.
    function automatic regfile_t write_r16(input regfile_t r, input regfile_r16_t sel,
                                           input logic [15:0] d);
        regfile_t o;
        o = r;
        case (sel)
            BC:      begin o.b = d[15:8]; o.c = d[7:0]; end
            DE:      begin o.d = d[15:8]; o.e = d[7:0]; end
            HL:      begin o.h = d[15:8]; o.l = d[7:0]; end
            WZ:      begin o.w = d[15:8]; o.z = d[7:0]; end
            SP:      o.sp = d;
            PC:      o.pc = d;
            default: o    = r;
        endcase
        return o;
    endfunction

    // Sources are applied lowest priority first so that a later, stronger
    // source overrides only the bytes it actually targets.
    always_comb begin
        nxt = registers;
        if (idu_wren)
            nxt = write_r16(nxt, idu_req, idu_data);
        if (data_bus_wren)
            nxt = write_r8(nxt, data_bus_req, data_bus_data);
        if (alu_wren) begin
            nxt = write_r8(nxt, alu_req, alu_data);
            if (!alu_skip_flags)
                nxt.flags = alu_flags;
        end
        // Adjust info and SP copy use the pre-edge register values.
        if (set_adj) begin
            nxt.adj_sign  = registers.z[7];
            nxt.adj_carry = alu_flags.c;
        end
        if (overwrite_sp)
            nxt.sp = {registers.h, registers.l};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            registers <= '0;
        else
            registers <= nxt;
    end

endmodule

// File: tb/tb_gb_cpu_regfile.sv
// Directed self-checking bench for gb_cpu_regfile.
module tb_gb_cpu_regfile;
    import gb_cpu_regfile_pkg::*;

    logic         clk;
    logic         reset;
    regfile_r8_t  alu_req;
    logic [7:0]   alu_data;
    alu_flags_t   alu_flags;
    logic         alu_wren;
    logic         alu_skip_flags;
    regfile_r16_t idu_req;
    logic [15:0]  idu_data;
    logic         idu_wren;
    regfile_r8_t  data_bus_req;
    logic [7:0]   data_bus_data;
    logic         data_bus_wren;
    logic         set_adj;
    logic         overwrite_sp;
    regfile_t     registers;

    int checks = 0;
    int errors = 0;

    gb_cpu_regfile dut (
        .clk            (clk),
        .reset          (reset),
        .alu_req        (alu_req),
        .alu_data       (alu_data),
        .alu_flags      (alu_flags),
        .alu_wren       (alu_wren),
        .alu_skip_flags (alu_skip_flags),
        .idu_req        (idu_req),
        .idu_data       (idu_data),
        .idu_wren       (idu_wren),
        .data_bus_req   (data_bus_req),
        .data_bus_data  (data_bus_data),
        .data_bus_wren  (data_bus_wren),
        .set_adj        (set_adj),
        .overwrite_sp   (overwrite_sp),
        .registers      (registers)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_req        = A;
        alu_data       = 8'h00;
        alu_flags      = 4'b0000;
        alu_wren       = 1'b0;
        alu_skip_flags = 1'b0;
        idu_req        = BC;
        idu_data       = 16'h0000;
        idu_wren       = 1'b0;
        data_bus_req   = A;
        data_bus_data  = 8'h00;
        data_bus_wren  = 1'b0;
        set_adj        = 1'b0;
        overwrite_sp   = 1'b0;
    endtask

    // Advance one edge and return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        idle();

        // Async reset between edges, no clock edge needed.
        #2 reset = 1'b0;
        #1;
        check("rst_a",     {24'h0, registers.a}, 32'h0);
        check("rst_flags", {28'h0, registers.flags}, 32'h0);
        check("rst_sp",    {16'h0, registers.sp}, 32'h0);
        check("rst_pc",    {16'h0, registers.pc}, 32'h0);
        check("rst_adj",   {30'h0, registers.adj_sign, registers.adj_carry}, 32'h0);

        // Writes ignored while reset is held.
        alu_req = A; alu_data = 8'h99; alu_wren = 1'b1;
        idu_req = PC; idu_data = 16'h1234; idu_wren = 1'b1;
        tick();
        check("rst_hold_a",  {24'h0, registers.a}, 32'h0);
        check("rst_hold_pc", {16'h0, registers.pc}, 32'h0);

        // Release; values hold until first write.
        idle();
        reset = 1'b1;
        tick();
        check("rel_a", {24'h0, registers.a}, 32'h0);

        // ALU write with flags.
        alu_req = A; alu_data = 8'h5A; alu_flags = 4'b1011; alu_wren = 1'b1;
        tick();
        check("alu_a",     {24'h0, registers.a}, 32'h5A);
        check("alu_flags", {28'h0, registers.flags}, 32'hB);

        // ALU write with flag update suppressed.
        alu_data = 8'h5B; alu_flags = 4'b0000; alu_skip_flags = 1'b1;
        tick();
        check("skip_a",     {24'h0, registers.a}, 32'h5B);
        check("skip_flags", {28'h0, registers.flags}, 32'hB);

        // No ALU write: flags hold even with skip low.
        idle();
        tick();
        check("nowr_flags", {28'h0, registers.flags}, 32'hB);
        check("nowr_a",     {24'h0, registers.a}, 32'h5B);

        // IDU pair writes.
        idu_wren = 1'b1; idu_req = HL; idu_data = 16'hC0DE;
        tick();
        check("idu_h", {24'h0, registers.h}, 32'hC0);
        check("idu_l", {24'h0, registers.l}, 32'hDE);
        idu_req = PC; idu_data = 16'h0150;
        tick();
        check("idu_pc", {16'h0, registers.pc}, 32'h0150);

        // SP assembled from byte writes.
        idle();
        data_bus_wren = 1'b1; data_bus_req = SPL; data_bus_data = 8'h34;
        tick();
        data_bus_req = SPH; data_bus_data = 8'h12;
        tick();
        check("bus_sp", {16'h0, registers.sp}, 32'h1234);

        // PC high-byte write leaves low byte alone.
        data_bus_req = PCH; data_bus_data = 8'hAB;
        tick();
        check("bus_pch", {16'h0, registers.pc}, 32'hAB50);

        // Simultaneous disjoint writes.
        idle();
        alu_wren = 1'b1; alu_req = A; alu_data = 8'h11; alu_skip_flags = 1'b1;
        data_bus_wren = 1'b1; data_bus_req = B; data_bus_data = 8'h22;
        idu_wren = 1'b1; idu_req = DE; idu_data = 16'h3344;
        tick();
        check("sim_a", {24'h0, registers.a}, 32'h11);
        check("sim_b", {24'h0, registers.b}, 32'h22);
        check("sim_d", {24'h0, registers.d}, 32'h33);
        check("sim_e", {24'h0, registers.e}, 32'h44);

        // ALU beats bus on the same byte.
        idle();
        alu_wren = 1'b1; alu_req = C; alu_data = 8'hAA; alu_skip_flags = 1'b1;
        data_bus_wren = 1'b1; data_bus_req = C; data_bus_data = 8'hBB;
        tick();
        check("conf_alu_bus_c", {24'h0, registers.c}, 32'hAA);

        // Bus beats IDU on C only; IDU still writes B.
        idle();
        data_bus_wren = 1'b1; data_bus_req = C; data_bus_data = 8'h55;
        idu_wren = 1'b1; idu_req = BC; idu_data = 16'h9966;
        tick();
        check("conf_bus_idu_b", {24'h0, registers.b}, 32'h99);
        check("conf_bus_idu_c", {24'h0, registers.c}, 32'h55);

        // overwrite_sp beats IDU SP write and an ALU SPH write.
        idle();
        idu_wren = 1'b1; idu_req = HL; idu_data = 16'hDFF0;
        tick();
        idle();
        overwrite_sp = 1'b1;
        idu_wren = 1'b1; idu_req = SP; idu_data = 16'h0000;
        alu_wren = 1'b1; alu_req = SPH; alu_data = 8'h00; alu_skip_flags = 1'b1;
        tick();
        check("ovr_sp", {16'h0, registers.sp}, 32'hDFF0);

        // overwrite_sp uses pre-edge HL while HL is being rewritten.
        idle();
        overwrite_sp = 1'b1;
        idu_wren = 1'b1; idu_req = HL; idu_data = 16'h1111;
        tick();
        check("ovr_pre_sp", {16'h0, registers.sp}, 32'hDFF0);
        check("ovr_pre_h",  {24'h0, registers.h}, 32'h11);

        // set_adj.
        idle();
        data_bus_wren = 1'b1; data_bus_req = Z; data_bus_data = 8'h80;
        tick();
        idle();
        set_adj = 1'b1; alu_flags = 4'b0001;
        tick();
        check("adj_set", {30'h0, registers.adj_sign, registers.adj_carry}, 32'h3);
        idle();
        tick();
        check("adj_hold", {30'h0, registers.adj_sign, registers.adj_carry}, 32'h3);

        // set_adj samples z before a same-cycle Z write.
        set_adj = 1'b1; alu_flags = 4'b0000;
        data_bus_wren = 1'b1; data_bus_req = Z; data_bus_data = 8'h00;
        tick();
        check("adj_pre_z", {30'h0, registers.adj_sign, registers.adj_carry}, 32'h2);
        check("adj_z",     {24'h0, registers.z}, 32'h00);

        // Reset mid-operation drops the pending write.
        idle();
        alu_wren = 1'b1; alu_req = A; alu_data = 8'hEE;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_a",  {24'h0, registers.a}, 32'h0);
        check("mid_rst_sp", {16'h0, registers.sp}, 32'h0);
        tick();
        check("mid_rst_hold_a", {24'h0, registers.a}, 32'h0);
        idle();
        reset = 1'b1;
        tick();
        check("mid_rel_a", {24'h0, registers.a}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
